// File: rtl/fifo_pkg.sv
// Shared helpers for sync_fifo_param: address/count width derivation and the error flag pair.
package fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

  // ADDR_W indexes memory; CNT_W adds the wrap bit so 0..DEPTH is representable.
  function automatic int addr_w(input int depth);
    return clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic ovf;
    logic unf;
  } err_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk)
    if (we) mem_q[waddr] <= wdata;

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, thresholds, sticky errors and synchronous flush.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module sync_fifo_param import fifo_pkg::*; #(
  parameter int   DATA_W    = 8,
  parameter int   DEPTH     = 8,
  parameter int   AF_THRESH = DEPTH - 2,
  parameter int   AE_THRESH = 1,
  localparam int  ADDR_W    = addr_w(DEPTH),
  localparam int  CNT_W     = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [CNT_W-1:0] AF_T = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_T = CNT_W'(AE_THRESH);

  logic [CNT_W-1:0]  w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  err_t              err_q, err_d;
  logic              w_acc, r_acc;
  logic [DATA_W-1:0] mem_rd;

  // Status decodes only from registered pointers.
  assign empty        = (w_ptr_q == r_ptr_q);
  assign full         = (w_ptr_q[ADDR_W-1:0] == r_ptr_q[ADDR_W-1:0]) &&
                        (w_ptr_q[ADDR_W] != r_ptr_q[ADDR_W]);
  assign count        = w_ptr_q - r_ptr_q;
  assign almost_empty = (count <= AE_T);
  assign almost_full  = (count >= AF_T);
  assign overflow     = err_q.ovf;
  assign underflow    = err_q.unf;

  assign w_acc = w_en && !full  && !clr;
  assign r_acc = r_en && !empty && !clr;

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk  (clk),
    .we   (w_acc),
    .waddr(w_ptr_q[ADDR_W-1:0]),
    .wdata(w_data),
    .raddr(r_ptr_q[ADDR_W-1:0]),
    .rdata(mem_rd)
  );

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    err_d   = err_q;
    if (clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      err_d   = '0;
    end else begin
      if (w_acc)         w_ptr_d = w_ptr_q + 1'b1;
      if (r_acc)         r_ptr_d = r_ptr_q + 1'b1;
      if (w_en && full)  err_d.ovf = 1'b1;
      if (r_en && empty) err_d.unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      err_q   <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      err_q   <= err_d;
    end

`ifdef SYNC_FIFO_FWFT_EN
  assign r_data  = mem_rd;
  assign r_valid = !empty;
`else
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              r_valid_q, r_valid_d;

  // r_acc is already gated by clr, so flush drops r_valid while r_data holds.
  always_comb begin
    r_data_d  = r_acc ? mem_rd : r_data_q;
    r_valid_d = r_acc;
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
    end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based reference model.
module tb_sync_fifo_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int AF     = 6;
  localparam int AE     = 1;

  logic              clk = 1'b0;
  logic              n_rst, clr, w_en, r_en;
  logic [DATA_W-1:0] w_data, r_data;
  logic              r_valid, empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0]        count;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .n_rst(n_rst), .clr(clr), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data), .r_valid(r_valid), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: contents as a queue plus sticky flags and the read register.
  logic [DATA_W-1:0] mq[$];
  bit                m_ovf, m_unf, m_rv;
  logic [DATA_W-1:0] m_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0;
    m_unf = 0;
    m_rv  = 0;
    m_rd  = '0;
  endtask

  task automatic check_all(input string ph);
    int n;
    n = mq.size();
    chk({ph, ".count"},  32'(count),        32'(n));
    chk({ph, ".empty"},  32'(empty),        32'(n == 0));
    chk({ph, ".full"},   32'(full),         32'(n == DEPTH));
    chk({ph, ".a_empty"},32'(almost_empty), 32'(n <= AE));
    chk({ph, ".a_full"}, 32'(almost_full),  32'(n >= AF));
    chk({ph, ".ovf"},    32'(overflow),     32'(m_ovf));
    chk({ph, ".unf"},    32'(underflow),    32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
    chk({ph, ".r_valid"}, 32'(r_valid), 32'(n > 0));
    if (n > 0) chk({ph, ".r_data"}, 32'(r_data), 32'(mq[0]));
`else
    chk({ph, ".r_valid"}, 32'(r_valid), 32'(m_rv));
    chk({ph, ".r_data"},  32'(r_data),  32'(m_rd));
`endif
  endtask

  task automatic step(input string ph, input bit w, input bit r, input bit c,
                      input logic [DATA_W-1:0] d);
    bit was_full, was_empty;
    w_en = w; r_en = r; clr = c; w_data = d;
    @(posedge clk);
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    if (c) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      m_rv  = 0;
    end else begin
      if (w && was_full)  m_ovf = 1;
      if (r && was_empty) m_unf = 1;
      m_rv = r && !was_empty;
      if (r && !was_empty) begin
`ifdef SYNC_FIFO_FWFT_EN
        void'(mq.pop_front());
`else
        m_rd = mq.pop_front();
`endif
      end
      if (w && !was_full) mq.push_back(d);
    end
    #1 check_all(ph);
  endtask

  initial begin
    int pw, pr;
    n_rst = 1'b0; clr = 1'b0; w_en = 1'b0; r_en = 1'b0; w_data = '0;
    model_reset();
    #1 check_all("reset");
    #20 @(negedge clk) n_rst = 1'b1;

    // Fill to full, then drain in order.
    for (int i = 1; i <= 8; i++) step("fill", 1, 0, 0, 8'(i));
    for (int i = 0; i < 8; i++)  step("drain", 0, 1, 0, 8'h00);
    step("drain_idle", 0, 0, 0, 8'h00);

    // Interleaved traffic wrapping the pointers twice.
    for (int i = 0; i < 20; i++) step("wrap", 1, (i % 4) != 0, 0, 8'(8'h40 + i));
    for (int i = 0; i < 10; i++) step("wrap_drain", 0, 1, 0, 8'h00);

    // Simultaneous read/write at full and at empty.
    step("clr0", 0, 0, 1, 8'h00);
    for (int i = 0; i < 8; i++) step("fill_aa", 1, 0, 0, 8'(8'hAA + i));
    step("full_rw", 1, 1, 0, 8'hCC);
    step("ovf_sticky", 0, 0, 0, 8'h00);
    step("clr1", 0, 0, 1, 8'h00);
    step("empty_rw", 1, 1, 0, 8'h55);
    step("unf_sticky", 0, 0, 0, 8'h00);

    // Flush after partial fill, then async reset mid-burst.
    for (int i = 0; i < 5; i++) step("pre_clr", 1, 0, 0, 8'(8'h10 + i));
    step("clr2", 0, 0, 1, 8'h00);
    step("post_clr", 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step("burst", 1, i > 1, 0, 8'(8'h20 + i));
    #2 n_rst = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk) n_rst = 1'b1;

    // Fall-through style single word: visible without r_en in FWFT mode.
    step("one_w", 1, 0, 0, 8'h3C);
    step("one_idle", 0, 0, 0, 8'h00);
    step("one_pop", 0, 1, 0, 8'h00);
    step("one_after", 0, 0, 0, 8'h00);

    // Random traffic with shifting write/read bias.
    for (int i = 0; i < 600; i++) begin
      case ((i / 100) % 3)
        0:       begin pw = 80; pr = 30; end
        1:       begin pw = 30; pr = 80; end
        default: begin pw = 60; pr = 60; end
      endcase
      step("rand", ($urandom % 100) < pw, ($urandom % 100) < pr,
           ($urandom % 100) < 2, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Synchronous single-clock FIFO, successor to the fixed 8x8 FIFO.
- Parametrised in width, depth and almost-full/almost-empty thresholds.
- Adds occupancy count, registered read data with valid strobe, sticky overflow/underflow error flags and a synchronous flush.
- Used as the general buffering element between producer/consumer pipeline stages in the same clock domain.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1).
- ADDR_W, $clog2(DEPTH), derived; never overridden.

Ports:
- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush; empties FIFO and clears error flags.
- w_en  in  1  write request.
- w_data  in  DATA_W  write data.
- r_en  in  1  read request.
- r_data  out  DATA_W  read data.
- r_valid  out  1  r_data holds a newly popped word this cycle.
- empty  out  1  no entries stored.
- full  out  1  DEPTH entries stored.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Pointers:
  - w_ptr and r_ptr are ADDR_W+1 bits; the low ADDR_W bits address memory, the MSB is the wrap bit.
  - Each pointer increments by 1 modulo 2^(ADDR_W+1). The wrap bit must toggle naturally on carry, unlike the old design.
- Status flags:
  - empty = (w_ptr == r_ptr).
  - full = low bits equal AND wrap bits differ.
  - count = w_ptr - r_ptr, modulo 2^(ADDR_W+1).
  - All status outputs decode from registered pointers only; there is no combinational path from w_en/r_en.
- Acceptance:
  - Write accepted iff w_en && !full && !clr.
  - Read accepted iff r_en && !empty && !clr.
- Simultaneous read and write:
  - Not full and not empty: both accepted; count unchanged.
  - When full: the read is accepted and the write is rejected; overflow is set.
  - When empty: the write is accepted and the read is rejected; underflow is set. No bypass.
- Write: on accept, mem[w_ptr[ADDR_W-1:0]] <= w_data at the rising edge, and w_ptr increments. Memory is written only on accept; there is no self-assignment else branch.
- Read latency: 1 cycle.
  - On accept, r_data <= mem[r_ptr[ADDR_W-1:0]], r_valid <= 1 and r_ptr increments.
  - Otherwise r_valid <= 0 and r_data holds its previous value.
- Errors:
  - overflow <= 1 on w_en && full.
  - underflow <= 1 on r_en && empty.
  - Both hold until clr or reset.
- clr (synchronous, highest priority after reset):
  - w_ptr, r_ptr, overflow, underflow and r_valid <= 0.
  - r_data holds; memory contents are untouched.
- Reset (async assert, deassert synchronised externally):
  - w_ptr = r_ptr = 0, r_data = 0, r_valid = 0, overflow = underflow = 0.
  - Hence empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = (AF_THRESH == 0 ? 1 : 0).
  - Memory is not reset.
- Reset mid-operation: all in-flight data is discarded, and the outputs take their reset values immediately on assertion.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined (first-word fall-through):
  - r_data continuously presents mem[r_ptr] (combinational read).
  - r_valid = !empty.
  - r_en acts as pop acknowledge; the accept rule is unchanged.
  - Read latency is 0.
  - r_data is don't-care while empty; reset r_data is not required.
- Undefined: registered 1-cycle read as described in Behaviour.

Decomposition:
- Package fifo_pkg holds:
  - a clog2 helper function for tool portability;
  - a localparam rule deriving ADDR_W and CNT_W;
  - a typedef for the error flag pair {overflow, underflow}.
- One natural sub-module: fifo_mem, a DEPTH x DATA_W array with one synchronous write port and one asynchronous read port.
- Pointer, flag and read-register logic stay in sync_fifo_param.

Test Plan:
1. DATA_W=8, DEPTH=8: reset, then write 0x01..0x08 on consecutive cycles -> full=1 and count=8 after the 8th edge; almost_full rises at count=6.
2. From full, read 8 times -> r_data sequence 0x01..0x08, each one cycle after its r_en with r_valid=1; empty=1 after the last accept.
3. Wrap-around: write and read 20 words interleaved (pointer wraps twice) -> data order preserved; count never exceeds 8; full/empty correct at each wrap.
4. Full with w_en=r_en=1 holding 0xAA..0xB1 -> oldest word popped, new word dropped, overflow=1 sticky, count=7. Empty with w_en=r_en=1 -> write accepted, underflow=1, count=1.
5. Write 5 words, assert clr for 1 cycle -> count=0, empty=1, overflow=underflow=0. Then assert n_rst low mid-burst -> all outputs at reset values asynchronously.
6. SYNC_FIFO_FWFT_EN defined: write 0x3C into the empty FIFO -> next cycle r_valid=1 and r_data=0x3C with no r_en; pulse r_en -> empty=1 on the following cycle.
